uart_rx_fifo: RTL and testbench

Receive buffer between the `uart` receiver and the CPU memory-mapped I/O decoder. Captures each byte the UART reports via `rx_new`/`rx_data`, acknowledges it so the UART can accept the next one, and stores it in a FIFO. The CPU drains the FIFO through the data register at 0x0001 and polls status at 0x0002. This removes byte loss when the CPU polls slower than the serial line delivers data.

---
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive buffer between the UART receiver and the CPU I/O decoder. Each new
// byte flagged by the UART is captured, acknowledged with a one-cycle pulse
// and queued; the CPU drains the queue through its data-register read strobe.
//
// Ports:
//   clki      system clock
//   rst       asynchronous active-high reset
//   rx_data   byte from the UART receiver, valid while rx_new is high
//   rx_new    UART "byte available" level flag
//   rx_ack    one-cycle pulse back to the UART that clears rx_new
//   bus_rd    CPU read strobe for the data register (level, many clki long)
//   bus_clr   one-cycle pulse clearing the overflow flag
//   data_out  byte at the FIFO head, 0 when empty
//   empty     FIFO holds no entries
//   full      FIFO holds DEPTH entries
//   count     number of stored entries, 0..DEPTH
//   overflow  sticky: a byte was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clki,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_new,
    output logic          rx_ack,
    input  logic          bus_rd,
    input  logic          bus_clr,
    output logic [7:0]    data_out,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          rx_new_q;
    logic          bus_rd_q;

    logic push_req;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic drop;

    // Both strobes are levels held far longer than a clki cycle; only their
    // rising edge counts as a request.
    assign push_req = rx_new & ~rx_new_q;
    assign pop_req  = bus_rd & ~bus_rd_q;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign do_pop  = pop_req & ~empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO
    // is still accepted in that case.
    assign do_push = push_req & (~full | do_pop);
    assign drop    = push_req & ~do_push;

    assign data_out = empty ? 8'h00 : mem[rp];

    always_ff @(posedge clki) begin
        if (do_push) begin
            mem[wp] <= rx_data;
        end
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            rx_new_q <= 1'b0;
            bus_rd_q <= 1'b0;
            rx_ack   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rx_new_q <= rx_new;
            bus_rd_q <= bus_rd;
            // Acknowledge every request, dropped or not, so the UART never stalls.
            rx_ack   <= push_req;

            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end

            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (bus_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs are driven and outputs sampled 1 ns
// after each rising clki edge.
module tb_uart_rx_fifo;

    logic       clki = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_new;
    logic       rx_ack;
    logic       bus_rd;
    logic       bus_clr;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clki     (clki),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_new   (rx_new),
        .rx_ack   (rx_ack),
        .bus_rd   (bus_rd),
        .bus_clr  (bus_clr),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #10 clki = ~clki;

    task automatic tick();
        @(posedge clki);
        #1;
    endtask

    // Holds rx_new for 'hold' cycles, then drops it for one cycle; returns
    // the number of rx_ack pulses seen.
    task automatic push_byte(input logic [7:0] b, input int hold, output int acks);
        rx_data = b;
        rx_new  = 1'b1;
        acks    = 0;
        repeat (hold) begin
            tick();
            if (rx_ack) acks++;
        end
        rx_new = 1'b0;
        tick();
        if (rx_ack) acks++;
    endtask

    // Samples data_out at the start of the strobe, holds bus_rd for 'hold'
    // cycles, then drops it for one cycle.
    task automatic pop_byte(input int hold, output logic [7:0] d);
        bus_rd = 1'b1;
        d      = data_out;
        repeat (hold) tick();
        bus_rd = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: empty=%b full=%b count=%0d, want empty=1 full=0 count=0", empty, full, count);
        end
        n_checks++;
        if (data_out !== 8'h00 || rx_ack !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: data_out=%h rx_ack=%b overflow=%b, want 00 0 0", data_out, rx_ack, overflow);
        end
    endtask

    task automatic test_basic();
        int acks;
        logic [7:0] d;
        logic [7:0] vals [3];
        vals[0] = 8'h41; vals[1] = 8'h42; vals[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            push_byte(vals[i], 10, acks);
            n_checks++;
            if (acks !== 1) begin
                n_fail++;
                $display("FAIL basic_ack[%0d]: got %0d pulses, want 1", i, acks);
            end
        end
        n_checks++;
        if (count !== 5'd3 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count: count=%0d empty=%b, want 3 0", count, empty);
        end
        for (int i = 0; i < 3; i++) begin
            pop_byte(32, d);
            n_checks++;
            if (d !== vals[i]) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %h want %h", i, d, vals[i]);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_empty: empty=%b data_out=%h, want 1 00", empty, data_out);
        end
    endtask

    task automatic test_overflow();
        int acks;
        logic [7:0] d;
        int bad = 0;
        for (int i = 0; i < 16; i++) push_byte(8'(i), 3, acks);
        n_checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fill: full=%b count=%0d overflow=%b, want 1 16 0", full, count, overflow);
        end
        push_byte(8'hAA, 3, acks);
        n_checks++;
        if (acks !== 1 || overflow !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_drop: acks=%0d overflow=%b count=%0d, want 1 1 16", acks, overflow, count);
        end
        for (int i = 0; i < 16; i++) begin
            pop_byte(4, d);
            if (d !== 8'(i)) begin
                bad++;
                $display("FAIL ovf_data[%0d]: got %h want %h", i, d, 8'(i));
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        n_checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: empty=%b overflow=%b, want 1 1", empty, overflow);
        end
        bus_clr = 1'b1;
        tick();
        bus_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: overflow=%b want 0", overflow);
        end
    endtask

    task automatic test_wrap();
        int acks;
        logic [7:0] d;
        int bad = 0;
        int max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(8'h80 + i), 2, acks);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            pop_byte(2, d);
            if (d !== 8'(8'h80 + i)) begin
                bad++;
                $display("FAIL wrap_data[%0d]: got %h want %h", i, d, 8'(8'h80 + i));
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        n_checks++;
        if (max_cnt != 1) begin
            n_fail++;
            $display("FAIL wrap_count: max count %0d, want 1", max_cnt);
        end
    endtask

    // Raises rx_new and bus_rd together so both edges land on one clock edge.
    task automatic same_edge(input logic [7:0] b);
        rx_data = b;
        rx_new  = 1'b1;
        bus_rd  = 1'b1;
        tick();
    endtask

    task automatic same_edge_release();
        rx_new = 1'b0;
        bus_rd = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int acks;
        logic [7:0] d;
        int bad = 0;
        // middle occupancy
        for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i), 2, acks);
        same_edge(8'h15);
        n_checks++;
        if (count !== 5'd5 || data_out !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_mid: count=%0d head=%h, want 5 11", count, data_out);
        end
        same_edge_release();
        for (int i = 0; i < 5; i++) begin
            pop_byte(2, d);
            if (d !== 8'(8'h11 + i)) begin
                bad++;
                $display("FAIL b2b_mid_data[%0d]: got %h want %h", i, d, 8'(8'h11 + i));
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
        // empty
        same_edge(8'h60);
        n_checks++;
        if (count !== 5'd1 || data_out !== 8'h60) begin
            n_fail++;
            $display("FAIL b2b_empty: count=%0d head=%h, want 1 60", count, data_out);
        end
        same_edge_release();
        pop_byte(2, d);
        // full
        for (int i = 0; i < 16; i++) push_byte(8'(8'hC0 + i), 2, acks);
        same_edge(8'h5A);
        n_checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || data_out !== 8'hC1) begin
            n_fail++;
            $display("FAIL b2b_full: count=%0d overflow=%b head=%h, want 16 0 c1", count, overflow, data_out);
        end
        same_edge_release();
        bad = 0;
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp;
            exp = (i == 16) ? 8'h5A : 8'(8'hC0 + i);
            pop_byte(2, d);
            if (d !== exp) begin
                bad++;
                $display("FAIL b2b_full_data[%0d]: got %h want %h", i, d, exp);
            end
        end
        n_checks++;
        if (bad != 0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_full_drain: errors=%0d empty=%b, want 0 1", bad, empty);
        end
    endtask

    task automatic test_async_reset();
        int acks;
        logic [7:0] d;
        for (int i = 0; i < 7; i++) push_byte(8'(8'h20 + i), 2, acks);
        n_checks++;
        if (count !== 5'd7) begin
            n_fail++;
            $display("FAIL arst_pre: count=%0d want 7", count);
        end
        bus_rd = 1'b1;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00 ||
            overflow !== 1'b0 || rx_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now: count=%0d empty=%b full=%b data_out=%h ovf=%b ack=%b, want 0 1 0 00 0 0",
                     count, empty, full, data_out, overflow, rx_ack);
        end
        @(posedge clki);
        #3 rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_release: count=%0d empty=%b, want 0 1", count, empty);
        end
        bus_rd = 1'b0;
        tick();
        push_byte(8'h77, 2, acks);
        pop_byte(2, d);
        n_checks++;
        if (d !== 8'h77 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_recover: got %h empty=%b, want 77 1", d, empty);
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_new  = 1'b0;
        bus_rd  = 1'b0;
        bus_clr = 1'b0;
        repeat (2) @(posedge clki);
        #3 rst = 1'b0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
